// File: rtl/vga_ram_pkg.sv
// Shared definitions for the VGA / secondary RAM port-B arbiter:
// read-owner tag encoding and the default starvation threshold.
package vga_ram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_VGA    = 2'd1,
    OWN_SEC_RD = 2'd2
  } owner_t;

  localparam int STARVE_LIMIT_DEF = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with load > clear > increment priority.
// One cycle from control input to updated count; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             pix_clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_ram_arbiter.sv
// Shares RAM port B: VGA always wins, secondary uses valid/ready; 2-edge read latency.
// Secondary is refused whenever vga_req is high; reads are tagged so data returns to its issuer.
module vga_ram_arbiter
  import vga_ram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  pix_clk,
  input  logic                  reset_n,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic                  vga_rvalid,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  input  logic                  sec_valid,
  output logic                  sec_ready,
  input  logic                  sec_we,
  input  logic [ADDR_WIDTH-1:0] sec_addr,
  input  logic [DATA_WIDTH-1:0] sec_wdata,
  output logic                  sec_rvalid,
  output logic [DATA_WIDTH-1:0] sec_rdata,
  input  logic                  frame_start,
  input  logic                  starve_clr,
  output logic                  sec_starved,
  output logic [15:0]           sec_frame_cnt,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  output logic [DATA_WIDTH-1:0] ram_d_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam logic [15:0] STARVE_THR = 16'(STARVE_LIMIT - 1);

  owner_t      tag;
  owner_t      rtag;
  logic        accept;
  logic        refused;
  logic [15:0] starve_cnt;
  logic [15:0] run_cnt;

  assign sec_ready = sec_valid & ~vga_req;
  assign accept    = sec_valid & sec_ready;
  assign refused   = sec_valid & ~sec_ready;

  assign vga_rvalid = (rtag == OWN_VGA);
  assign sec_rvalid = (rtag == OWN_SEC_RD);
  assign vga_rdata  = ram_q_b;
  assign sec_rdata  = ram_q_b;

  // Issue register plus a one-deep tag delay matching the RAM read latency.
  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr_b <= '0;
      ram_we_b   <= 1'b0;
      ram_d_b    <= '0;
      tag        <= OWN_NONE;
      rtag       <= OWN_NONE;
    end else begin
      rtag <= tag;
      if (vga_req) begin
        ram_addr_b <= vga_addr;
        ram_we_b   <= 1'b0;
        ram_d_b    <= '0;
        tag        <= OWN_VGA;
      end else if (accept) begin
        ram_addr_b <= sec_addr;
        ram_we_b   <= sec_we;
        ram_d_b    <= sec_wdata;
        tag        <= sec_we ? OWN_NONE : OWN_SEC_RD;
      end else begin
        ram_addr_b <= '0;
        ram_we_b   <= 1'b0;
        ram_d_b    <= '0;
        tag        <= OWN_NONE;
      end
    end
  end

  sat_counter #(.WIDTH(16)) u_starve_cnt (
    .pix_clk  (pix_clk),
    .reset_n  (reset_n),
    .clr      (~sec_valid | accept),
    .inc      (refused),
    .load     (1'b0),
    .load_val (16'd0),
    .cnt      (starve_cnt)
  );

  // An accept coincident with frame_start belongs to the new frame.
  sat_counter #(.WIDTH(16)) u_frame_cnt (
    .pix_clk  (pix_clk),
    .reset_n  (reset_n),
    .clr      (1'b0),
    .inc      (accept),
    .load     (frame_start),
    .load_val ({15'd0, accept}),
    .cnt      (run_cnt)
  );

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_starved   <= 1'b0;
      sec_frame_cnt <= 16'd0;
    end else begin
      if (refused && (starve_cnt >= STARVE_THR)) begin
        sec_starved <= 1'b1;
      end else if (starve_clr) begin
        sec_starved <= 1'b0;
      end
      if (frame_start) begin
        sec_frame_cnt <= run_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed bench for vga_ram_arbiter against a behavioural synchronous RAM.
module tb_vga_ram_arbiter;

  logic        pix_clk = 1'b0;
  logic        reset_n;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_rvalid;
  logic [15:0] vga_rdata;
  logic        sec_valid;
  logic        sec_ready;
  logic        sec_we;
  logic [15:0] sec_addr;
  logic [15:0] sec_wdata;
  logic        sec_rvalid;
  logic [15:0] sec_rdata;
  logic        frame_start;
  logic        starve_clr;
  logic        sec_starved;
  logic [15:0] sec_frame_cnt;
  logic [15:0] ram_addr_b;
  logic        ram_we_b;
  logic [15:0] ram_d_b;
  logic [15:0] ram_q_b;

  logic [15:0] mem [0:65535];

  int tests = 0;
  int fails = 0;

  always #20 pix_clk = ~pix_clk;

  always @(posedge pix_clk) begin
    if (ram_we_b) mem[ram_addr_b] <= ram_d_b;
    ram_q_b <= mem[ram_addr_b];
  end

  vga_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(64)) dut (
    .pix_clk       (pix_clk),
    .reset_n       (reset_n),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_rvalid    (vga_rvalid),
    .vga_rdata     (vga_rdata),
    .sec_valid     (sec_valid),
    .sec_ready     (sec_ready),
    .sec_we        (sec_we),
    .sec_addr      (sec_addr),
    .sec_wdata     (sec_wdata),
    .sec_rvalid    (sec_rvalid),
    .sec_rdata     (sec_rdata),
    .frame_start   (frame_start),
    .starve_clr    (starve_clr),
    .sec_starved   (sec_starved),
    .sec_frame_cnt (sec_frame_cnt),
    .ram_addr_b    (ram_addr_b),
    .ram_we_b      (ram_we_b),
    .ram_d_b       (ram_d_b),
    .ram_q_b       (ram_q_b)
  );

  typedef struct {
    logic        vreq;
    logic [15:0] vaddr;
    logic        sv;
    logic        swe;
    logic [15:0] saddr;
    logic [15:0] swd;
    logic        e_rdy;
    logic [15:0] e_addr;
    logic        e_we;
    logic [15:0] e_d;
    logic        e_vrv;
    logic        e_srv;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic idle_inputs();
    vga_req   = 1'b0;
    vga_addr  = 16'h0;
    sec_valid = 1'b0;
    sec_we    = 1'b0;
    sec_addr  = 16'h0;
    sec_wdata = 16'h0;
  endtask

  task automatic sec_write(input logic [15:0] a, input logic [15:0] d);
    sec_valid = 1'b1; sec_we = 1'b1; sec_addr = a; sec_wdata = d;
    tick();
    idle_inputs();
  endtask

  task automatic sec_cycles(input int n);
    sec_valid = 1'b1; sec_we = 1'b0; sec_addr = 16'h0;
    repeat (n) tick();
    sec_valid = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8001, 16'h0000, 1'b1, 16'h8001, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1111};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8002, 16'hBEEF, 1'b1, 16'h8002, 1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h2222};
    tbl[6]  = '{1'b1, 16'h0010, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1111};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8002, 16'h0000, 1'b1, 16'h8002, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};

    idle_inputs();
    frame_start = 1'b0;
    starve_clr  = 1'b0;
    reset_n     = 1'b0;
    #5;
    chk("rst_addr", 32'(ram_addr_b), 32'h0);
    chk("rst_we", 32'(ram_we_b), 32'h0);
    chk("rst_d", 32'(ram_d_b), 32'h0);
    chk("rst_vrv", 32'(vga_rvalid), 32'h0);
    chk("rst_srv", 32'(sec_rvalid), 32'h0);
    chk("rst_starved", 32'(sec_starved), 32'h0);
    chk("rst_fcnt", 32'(sec_frame_cnt), 32'h0);
    chk("rst_ready", 32'(sec_ready), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Preload RAM through the arbiter's own write path.
    sec_write(16'h8000, 16'h0123);
    sec_write(16'h0010, 16'h1111);
    sec_write(16'h8001, 16'h2222);
    tick(); tick();

    for (int i = 0; i < 11; i++) begin
      vga_req   = tbl[i].vreq;
      vga_addr  = tbl[i].vaddr;
      sec_valid = tbl[i].sv;
      sec_we    = tbl[i].swe;
      sec_addr  = tbl[i].saddr;
      sec_wdata = tbl[i].swd;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(sec_ready), 32'(tbl[i].e_rdy));
      tick();
      chk($sformatf("v%0d_addr", i), 32'(ram_addr_b), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_we", i), 32'(ram_we_b), 32'(tbl[i].e_we));
      chk($sformatf("v%0d_d", i), 32'(ram_d_b), 32'(tbl[i].e_d));
      chk($sformatf("v%0d_vrv", i), 32'(vga_rvalid), 32'(tbl[i].e_vrv));
      chk($sformatf("v%0d_srv", i), 32'(sec_rvalid), 32'(tbl[i].e_srv));
      if (tbl[i].e_vrv) chk($sformatf("v%0d_vdata", i), 32'(vga_rdata), 32'(tbl[i].e_rd));
      if (tbl[i].e_srv) chk($sformatf("v%0d_sdata", i), 32'(sec_rdata), 32'(tbl[i].e_rd));
    end
    idle_inputs();
    tick();

    // Starvation: 70 refused cycles under continuous VGA traffic.
    vga_req = 1'b1; vga_addr = 16'h0010;
    sec_valid = 1'b1; sec_we = 1'b0; sec_addr = 16'h8001;
    for (int i = 1; i <= 70; i++) begin
      #1;
      chk("starve_refuse", 32'(sec_ready), 32'h0);
      tick();
      if (i == 63) chk("starve_63", 32'(sec_starved), 32'h0);
      if (i == 64) chk("starve_64", 32'(sec_starved), 32'h1);
    end
    vga_req = 1'b0;
    #1;
    chk("starve_accept_rdy", 32'(sec_ready), 32'h1);
    tick();
    chk("starve_accept_addr", 32'(ram_addr_b), 32'h8001);
    chk("starve_sticky1", 32'(sec_starved), 32'h1);
    idle_inputs();
    tick(); tick();
    chk("starve_sticky2", 32'(sec_starved), 32'h1);
    starve_clr = 1'b1;
    tick();
    starve_clr = 1'b0;
    chk("starve_cleared", 32'(sec_starved), 32'h0);

    // Set and clear in the same cycle: set wins.
    vga_req = 1'b1; sec_valid = 1'b1;
    repeat (63) tick();
    chk("setwin_pre", 32'(sec_starved), 32'h0);
    starve_clr = 1'b1;
    tick();
    chk("setwin", 32'(sec_starved), 32'h1);
    idle_inputs();
    tick();
    chk("setwin_clr", 32'(sec_starved), 32'h0);
    starve_clr = 1'b0;

    // Per-frame accept counter.
    frame_pulse();
    sec_cycles(5);
    frame_pulse();
    chk("frame_5", 32'(sec_frame_cnt), 32'd5);
    sec_cycles(2);
    frame_start = 1'b1; sec_valid = 1'b1;
    tick();
    frame_start = 1'b0; sec_valid = 1'b0;
    chk("frame_2", 32'(sec_frame_cnt), 32'd2);
    frame_pulse();
    chk("frame_carry", 32'(sec_frame_cnt), 32'd1);
    frame_pulse();
    chk("frame_empty", 32'(sec_frame_cnt), 32'd0);
    sec_cycles(3);
    frame_pulse();

    // Asynchronous reset with a secondary read in flight.
    sec_valid = 1'b1; sec_we = 1'b0; sec_addr = 16'h8000;
    tick();
    idle_inputs();
    chk("inflight_addr", 32'(ram_addr_b), 32'h8000);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_addr", 32'(ram_addr_b), 32'h0);
    chk("arst_we", 32'(ram_we_b), 32'h0);
    chk("arst_srv", 32'(sec_rvalid), 32'h0);
    chk("arst_vrv", 32'(vga_rvalid), 32'h0);
    chk("arst_fcnt", 32'(sec_frame_cnt), 32'h0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_srv", 32'(sec_rvalid), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_ram_arbiter.md
# vga_ram_arbiter

Shares the single read/write port B of the CPU data RAM between the VGA sprite/position fetch path, which must never stall, and one secondary requester (CPU-side I/O DMA or game-state writer) using a valid/ready handshake. Sits between the VGA top and the RAM port-B pins. Tags every issued read so returned data is steered to the requester that issued it. Keeps a starvation monitor and a per-frame grant count for bring-up.

## Interface
Parameters:
- ADDR_WIDTH, 16, RAM word-address width
- DATA_WIDTH, 16, RAM word width
- STARVE_LIMIT, 64, consecutive cycles of refused sec_valid that set sec_starved (1..65535)

Ports:
- pix_clk  in  1  sole clock, 25 MHz pixel clock
- reset_n  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA read request this cycle (no handshake, always granted)
- vga_addr  in  ADDR_WIDTH  VGA read address
- vga_rvalid  out  1  vga_rdata holds data for a VGA read
- vga_rdata  out  DATA_WIDTH  read data to VGA (ram_q_b passthrough)
- sec_valid  in  1  secondary request pending
- sec_ready  out  1  secondary request accepted this cycle
- sec_we  in  1  1 = write, 0 = read
- sec_addr  in  ADDR_WIDTH  secondary address
- sec_wdata  in  DATA_WIDTH  secondary write data
- sec_rvalid  out  1  sec_rdata holds data for a secondary read
- sec_rdata  out  DATA_WIDTH  read data to secondary (ram_q_b passthrough)
- frame_start  in  1  one-cycle pulse at vblank start
- starve_clr  in  1  clears sec_starved
- sec_starved  out  1  sticky starvation flag
- sec_frame_cnt  out  16  secondary accepts counted in the previous frame
- ram_addr_b  out  ADDR_WIDTH  RAM address, registered
- ram_we_b  out  1  RAM write enable, registered
- ram_d_b  out  DATA_WIDTH  RAM write data, registered
- ram_q_b  in  DATA_WIDTH  RAM read data, valid one cycle after address

## Operation
- Fixed priority, VGA absolute. vga_req=1 wins; sec_ready=0 that cycle.
- sec_ready = sec_valid & !vga_req (combinational). A transfer occurs when sec_valid & sec_ready. Back-to-back accepts are allowed every cycle.
- Issue register updates every edge from the winner:
  - VGA: vga_addr, we=0.
  - Secondary: sec_addr, sec_we, sec_wdata.
  - None: addr=0, we=0, d=0.
- Owner tag is NONE/VGA/SEC_RD. A secondary write tags NONE. The tag registers alongside the issue register and is delayed one more stage as rtag.
- vga_rvalid = (rtag==VGA). sec_rvalid = (rtag==SEC_RD). Never both.
- Starvation counter: increments (saturating at 16 bits) while sec_valid & !sec_ready. Clears to 0 on accept or when sec_valid=0. Reaching STARVE_LIMIT sets sec_starved. sec_starved clears only on starve_clr. If the set and clear conditions occur in the same cycle, set wins.
- Frame counter: running count of secondary accepts, saturating at 16'hFFFF. On frame_start, sec_frame_cnt ← running count and the running count resets (to 1 if an accept occurs that same cycle, else 0).
- Reset (asynchronous, any time): issue register, tags, counters and flags go to 0. In-flight reads are discarded with no rvalid.

## Timing
- Request sampled at edge k. ram_addr_b/we/d valid k..k+1. RAM captures at k+1. ram_q_b and the matching rvalid are high k+1..k+2. The requester samples at edge k+2, so read latency is 2 edges.
- Writes occupy the port for one cycle: ram_we_b is high for exactly one cycle per accepted write, with no rvalid.
- Reset values: ram_addr_b=0, ram_we_b=0, ram_d_b=0, vga_rvalid=0, sec_rvalid=0, sec_starved=0, sec_frame_cnt=0. vga_rdata and sec_rdata follow ram_q_b. sec_ready is combinational and is 0 whenever sec_valid=0.
- sec_ready may drop while sec_valid is held. The secondary must hold sec_valid and its payload until accepted.

## Structure
- Package vga_ram_pkg holds:
  - owner encoding: OWN_NONE=2'd0, OWN_VGA=2'd1, OWN_SEC_RD=2'd2
  - default STARVE_LIMIT
- One sub-module, sat_counter (parameterised width, inc/clr/load). It is used for both the starvation counter and the frame counter.
- The issue/tag pipeline and the priority mux stay in the top.

## Test plan
- Secondary read of 0x8000 (RAM holds 0x0123) with vga_req=0: sec_ready=1 same cycle; ram_addr_b=0x8000 next cycle; sec_rvalid=1 with sec_rdata=0x0123 the cycle after; vga_rvalid=0 throughout.
- vga_req=1 every cycle for 70 cycles with sec_valid=1 held (STARVE_LIMIT=64): no accept; sec_starved rises on the 64th refused cycle; once vga_req drops, the first accept occurs and the flag stays set until a starve_clr pulse.
- Alternating VGA read 0x0010, secondary read 0x8001, secondary write 0x8002←0xBEEF: each rvalid goes only to its issuer in order; a later read of 0x8002 returns 0xBEEF; ram_we_b high exactly one cycle.
- Five accepts, then frame_start, then two accepts, then frame_start: sec_frame_cnt=5 then 2; an accept coincident with frame_start counts toward the next frame.
- Assert reset_n=0 while a secondary read is in flight: all outputs are 0 immediately; no sec_rvalid after release.
- vga_req and sec_valid both rise in the same cycle for one cycle: VGA is issued; the secondary is accepted the following cycle; the returns come out in order, VGA then SEC.
